hazard_detect: RTL and testbench
================================

Name: hazard_detect

Overview:
- Pipeline hazard detection unit for the 5-stage MIPS core, sitting directly upstream of the hazard/forward arbiter.
- Compares decode-stage source registers against execute- and memory-stage destinations.
- Tracks multi-cycle stall conditions with a small FSM: load-use, data-memory wait, taken-branch flush, halt.
- Drives the per-latch flush/enable requests and conflict flags that the arbiter combines with forwarding.

Parameters:
- REG_W, 5, register-select width.
- BFLUSH_CYC, 1, number of ihit-qualified cycles fetch/decode stays flushed after a taken branch (1..3).

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- dmem_req  in  1  memory stage holds a load/store awaiting dhit
- dec_rs, dec_rt  in  REG_W  decode-stage source selects
- ex_wsel  in  REG_W  execute-stage destination
- ex_wen, ex_mem_to_reg  in  1  execute-stage regwrite / load
- mem_wsel  in  REG_W  memory-stage destination
- mem_wen  in  1  memory-stage regwrite
- mem_branch_taken  in  1  branch/jump resolved taken in memory stage
- mem_halt  in  1  halt reached memory stage
- hu_fetch_decode_flush, hu_fetch_decode_enable  out  1
- hu_decode_execute_flush, hu_decode_execute_enable  out  1
- hu_execute_memory_flush, hu_execute_memory_enable  out  1
- hu_memory_write_back_flush, hu_memory_write_back_enable  out  1
- hu_decode_execute_conflict  out  1  decode source matches execute destination
- hu_decode_memory_conflict  out  1  decode source matches memory destination
- hu_is_mem  out  1  execute stage holds a load (= ex_mem_to_reg)
- halt  out  1  sticky halt

Behaviour:
- CLK/nRST: one clock; nRST is asynchronous and active-low.
- Reset: state=RUN, bflush counter=0, halt=0. All flushes 0, all enables 0 while nRST low.
- Conflict flags (combinational):
  - de_conflict = ex_wen & (ex_wsel!=0) & (ex_wsel==dec_rs | ex_wsel==dec_rt).
  - dm_conflict is the same form using mem_wen/mem_wsel.
  - Register $0 never conflicts.
- adv = ihit & (!dmem_req | dhit).
- States: RUN, LOAD_STALL, MEM_WAIT, BRANCH_FLUSH, HALTED.
- Priority when evaluating RUN: halt > branch > mem wait > load-use > normal.
- RUN outputs:
  - Normal: all enables=adv, flushes 0.
  - mem_halt & adv: MW enable=1, others 0; next=HALTED.
  - mem_branch_taken & adv: FD, DE, EM flush=1, MW enable=1; load bflush counter=BFLUSH_CYC-1; next=BRANCH_FLUSH (or RUN if BFLUSH_CYC==1).
  - dmem_req & !dhit: all enables 0; next=MEM_WAIT.
  - Load-use (de_conflict & ex_mem_to_reg) & adv: FD enable 0, DE flush=1, EM/MW enable=1; next=LOAD_STALL.
- LOAD_STALL:
  - Exactly one bubble was inserted; FD enable=adv, others=adv.
  - Next=RUN on adv, else hold.
- MEM_WAIT:
  - All enables 0 until dhit; on dhit, all enables=ihit.
  - Next=RUN when dhit & ihit.
  - dhit without ihit goes to RUN with enables 0.
- BRANCH_FLUSH:
  - FD flush=1 on each ihit, others=adv; counter decrements on ihit.
  - Next=RUN at counter 0.
  - mem_halt here takes priority (HALTED).
- HALTED: all enables 0, flushes 0, halt=1; left only via nRST.
- Reset mid-stall: returns to RUN immediately; pending counter cleared.
- ihit=0 in any non-HALTED state: no enables asserted; state holds except the MEM_WAIT exit rule above.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0], reset to 0.
  - stall_cnt increments each cycle in LOAD_STALL or MEM_WAIT, or on a RUN-state load-use/mem-wait entry.
  - flush_cnt increments on each taken-branch event.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: nRST=0 mid-MEM_WAIT, ihit=1 -> all outputs 0, state RUN. Release: first ihit -> all enables 1.
- Load-use: ex_wsel=5, ex_wen=1, ex_mem_to_reg=1, dec_rs=5, ihit=1 -> de_conflict=1, FD enable 0, DE flush 1. Next ihit cycle -> all enables 1.
- $0 guard: ex_wsel=0, ex_wen=1, dec_rt=0 -> de_conflict=0, no stall.
- Memory wait: dmem_req=1, dhit=0 for 3 cycles, ihit=1 -> all enables 0 for 3 cycles. dhit=1 -> all enables 1, state RUN.
- Branch: BFLUSH_CYC=2, mem_branch_taken=1, ihit=1 -> FD/DE/EM flush 1. Next ihit -> FD flush 1. Following ihit -> no flush.
- Halt vs branch: mem_halt=1 and mem_branch_taken=1 same cycle -> HALTED, halt=1, no flushes. Further ihit pulses -> enables stay 0.

Source files
------------

// File: rtl/hazard_detect_if.sv
// Hazard unit bundle: pipeline status in from the core, latch flush/enable requests out.
// With HAZARD_PERF_CNT_EN defined, the stall/flush counters are carried here as well.
interface hazard_detect_if #(
  parameter int REG_W = 5
);
  logic             ihit;
  logic             dhit;
  logic             dmem_req;
  logic [REG_W-1:0] dec_rs;
  logic [REG_W-1:0] dec_rt;
  logic [REG_W-1:0] ex_wsel;
  logic             ex_wen;
  logic             ex_mem_to_reg;
  logic [REG_W-1:0] mem_wsel;
  logic             mem_wen;
  logic             mem_branch_taken;
  logic             mem_halt;

  logic             hu_fetch_decode_flush;
  logic             hu_fetch_decode_enable;
  logic             hu_decode_execute_flush;
  logic             hu_decode_execute_enable;
  logic             hu_execute_memory_flush;
  logic             hu_execute_memory_enable;
  logic             hu_memory_write_back_flush;
  logic             hu_memory_write_back_enable;
  logic             hu_decode_execute_conflict;
  logic             hu_decode_memory_conflict;
  logic             hu_is_mem;
  logic             halt;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;
`endif

  modport master (
    output ihit, dhit, dmem_req, dec_rs, dec_rt, ex_wsel, ex_wen, ex_mem_to_reg,
           mem_wsel, mem_wen, mem_branch_taken, mem_halt,
    input  hu_fetch_decode_flush, hu_fetch_decode_enable,
           hu_decode_execute_flush, hu_decode_execute_enable,
           hu_execute_memory_flush, hu_execute_memory_enable,
           hu_memory_write_back_flush, hu_memory_write_back_enable,
           hu_decode_execute_conflict, hu_decode_memory_conflict, hu_is_mem, halt
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  ihit, dhit, dmem_req, dec_rs, dec_rt, ex_wsel, ex_wen, ex_mem_to_reg,
           mem_wsel, mem_wen, mem_branch_taken, mem_halt,
    output hu_fetch_decode_flush, hu_fetch_decode_enable,
           hu_decode_execute_flush, hu_decode_execute_enable,
           hu_execute_memory_flush, hu_execute_memory_enable,
           hu_memory_write_back_flush, hu_memory_write_back_enable,
           hu_decode_execute_conflict, hu_decode_memory_conflict, hu_is_mem, halt
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/hazard_detect.sv
// Hazard detection for the 5-stage core: register conflicts plus a stall/flush sequencer.
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state        | meaning
// RUN          | normal issue; hazards evaluated halt > branch > mem wait > load-use
// LOAD_STALL   | one bubble inserted behind a load, waiting for the next advance
// MEM_WAIT     | memory stage waiting for dhit, whole pipe frozen
// BRANCH_FLUSH | extra fetch/decode flush cycles after a taken branch
// HALTED       | pipe frozen until reset
module hazard_detect #(
  parameter int REG_W      = 5,
  parameter int BFLUSH_CYC = 1
) (
  input logic          CLK,
  input logic          nRST,
  hazard_detect_if.slave hif
);

  typedef enum logic [2:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT,
    BRANCH_FLUSH,
    HALTED
  } state_t;

  localparam logic [1:0] BCNT_LOAD = 2'(BFLUSH_CYC - 1);

  state_t     state_q, state_d;
  logic [1:0] bcnt_q, bcnt_d;

  logic [REG_W-1:0] rs, rt, ex_sel, mem_sel;
  logic             de_conflict, dm_conflict, load_use, adv;

  logic fd_fl, fd_en, de_fl, de_en, em_fl, em_en, mw_fl, mw_en;
  logic branch_evt;

  assign rs      = hif.dec_rs;
  assign rt      = hif.dec_rt;
  assign ex_sel  = hif.ex_wsel;
  assign mem_sel = hif.mem_wsel;

  // $0 is hardwired, so writes to it never create a dependency
  assign de_conflict = hif.ex_wen && (ex_sel != '0) && ((ex_sel == rs) || (ex_sel == rt));
  assign dm_conflict = hif.mem_wen && (mem_sel != '0) && ((mem_sel == rs) || (mem_sel == rt));
  assign load_use    = de_conflict && hif.ex_mem_to_reg;
  assign adv         = hif.ihit && (!hif.dmem_req || hif.dhit);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      bcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    fd_fl      = 1'b0;
    fd_en      = 1'b0;
    de_fl      = 1'b0;
    de_en      = 1'b0;
    em_fl      = 1'b0;
    em_en      = 1'b0;
    mw_fl      = 1'b0;
    mw_en      = 1'b0;
    branch_evt = 1'b0;

    case (state_q)
      RUN: begin
        if (hif.mem_halt && adv) begin
          mw_en   = 1'b1;
          state_d = HALTED;
        end else if (hif.mem_branch_taken && adv) begin
          branch_evt = 1'b1;
          fd_fl      = 1'b1;
          de_fl      = 1'b1;
          em_fl      = 1'b1;
          mw_en      = 1'b1;
          if (BFLUSH_CYC > 1) begin
            bcnt_d  = BCNT_LOAD;
            state_d = BRANCH_FLUSH;
          end
        end else if (hif.dmem_req && !hif.dhit) begin
          // without ihit the state holds; outputs are all-low either way
          if (hif.ihit) state_d = MEM_WAIT;
        end else if (load_use && adv) begin
          de_fl   = 1'b1;
          em_en   = 1'b1;
          mw_en   = 1'b1;
          state_d = LOAD_STALL;
        end else begin
          fd_en = adv;
          de_en = adv;
          em_en = adv;
          mw_en = adv;
        end
      end

      LOAD_STALL: begin
        fd_en = adv;
        de_en = adv;
        em_en = adv;
        mw_en = adv;
        if (adv) state_d = RUN;
      end

      MEM_WAIT: begin
        if (hif.dhit) begin
          fd_en   = hif.ihit;
          de_en   = hif.ihit;
          em_en   = hif.ihit;
          mw_en   = hif.ihit;
          state_d = RUN;
        end
      end

      BRANCH_FLUSH: begin
        if (hif.mem_halt && adv) begin
          mw_en   = 1'b1;
          bcnt_d  = 2'd0;
          state_d = HALTED;
        end else if (hif.ihit) begin
          fd_fl  = 1'b1;
          de_en  = adv;
          em_en  = adv;
          mw_en  = adv;
          bcnt_d = bcnt_q - 2'd1;
          if (bcnt_q <= 2'd1) state_d = RUN;
        end
      end

      HALTED: begin
      end

      default: state_d = RUN;
    endcase
  end

  // requests are forced low combinationally while reset is held
  assign hif.hu_fetch_decode_flush        = fd_fl && nRST;
  assign hif.hu_fetch_decode_enable       = fd_en && nRST;
  assign hif.hu_decode_execute_flush      = de_fl && nRST;
  assign hif.hu_decode_execute_enable     = de_en && nRST;
  assign hif.hu_execute_memory_flush      = em_fl && nRST;
  assign hif.hu_execute_memory_enable     = em_en && nRST;
  assign hif.hu_memory_write_back_flush   = mw_fl && nRST;
  assign hif.hu_memory_write_back_enable  = mw_en && nRST;
  assign hif.hu_decode_execute_conflict   = de_conflict;
  assign hif.hu_decode_memory_conflict    = dm_conflict;
  assign hif.hu_is_mem                    = hif.ex_mem_to_reg;
  assign hif.halt                         = (state_q == HALTED);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        stall_evt;

  always_comb begin
    stall_evt   = (state_q == LOAD_STALL) || (state_q == MEM_WAIT) ||
                  ((state_q == RUN) && ((state_d == LOAD_STALL) || (state_d == MEM_WAIT)));
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (branch_evt && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hif.stall_cnt = stall_cnt_q;
  assign hif.flush_cnt = flush_cnt_q;
`else
  logic unused_branch_evt;
  assign unused_branch_evt = branch_evt;
`endif

endmodule

// File: tb/tb_hazard_detect.sv
// Directed bench for hazard_detect (BFLUSH_CYC=2) with a per-cycle behavioural model check.
module tb_hazard_detect;
  localparam int BF = 2;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  hazard_detect_if #(.REG_W(5)) hif ();
  hazard_detect #(.REG_W(5), .BFLUSH_CYC(BF)) dut (.CLK(CLK), .nRST(nRST), .hif(hif));

  int errors = 0;
  int checks = 0;

  logic [3:0] en_vec, fl_vec;
  assign en_vec = {hif.hu_fetch_decode_enable, hif.hu_decode_execute_enable,
                   hif.hu_execute_memory_enable, hif.hu_memory_write_back_enable};
  assign fl_vec = {hif.hu_fetch_decode_flush, hif.hu_decode_execute_flush,
                   hif.hu_execute_memory_flush, hif.hu_memory_write_back_flush};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // model: pipeline status expressed as pending obligations, not as FSM states
  bit m_halted, m_bubble, m_memwait;
  int m_flush_left;
  bit n_halted, n_bubble, n_memwait;
  int n_flush_left;

  always @(negedge CLK) begin : model_cmp
    logic adv, e_de, e_dm;
    logic [3:0] e_en, e_fl;
    adv  = hif.ihit & (~hif.dmem_req | hif.dhit);
    e_de = hif.ex_wen && (hif.ex_wsel != 0) &&
           (hif.ex_wsel == hif.dec_rs || hif.ex_wsel == hif.dec_rt);
    e_dm = hif.mem_wen && (hif.mem_wsel != 0) &&
           (hif.mem_wsel == hif.dec_rs || hif.mem_wsel == hif.dec_rt);
    e_en = 4'b0;
    e_fl = 4'b0;
    n_halted = m_halted; n_bubble = m_bubble; n_memwait = m_memwait;
    n_flush_left = m_flush_left;
    if (!nRST || m_halted) begin
    end else if (m_memwait) begin
      if (hif.dhit) begin
        e_en = {4{hif.ihit}};
        n_memwait = 0;
      end
    end else if (m_bubble) begin
      e_en = {4{adv}};
      if (adv) n_bubble = 0;
    end else if (m_flush_left > 0) begin
      if (hif.mem_halt && adv) begin
        e_en = 4'b0001; n_halted = 1; n_flush_left = 0;
      end else if (hif.ihit) begin
        e_fl = 4'b1000; e_en = {1'b0, {3{adv}}};
        n_flush_left = m_flush_left - 1;
      end
    end else if (hif.mem_halt && adv) begin
      e_en = 4'b0001; n_halted = 1;
    end else if (hif.mem_branch_taken && adv) begin
      e_fl = 4'b1110; e_en = 4'b0001; n_flush_left = BF - 1;
    end else if (hif.dmem_req && !hif.dhit) begin
      if (hif.ihit) n_memwait = 1;
    end else if (e_de && hif.ex_mem_to_reg && adv) begin
      e_fl = 4'b0100; e_en = 4'b0011; n_bubble = 1;
    end else begin
      e_en = {4{adv}};
    end
    chk("m_enables", en_vec, e_en);
    chk("m_flushes", fl_vec, e_fl);
    chk("m_de_conflict", hif.hu_decode_execute_conflict, e_de);
    chk("m_dm_conflict", hif.hu_decode_memory_conflict, e_dm);
    chk("m_is_mem", hif.hu_is_mem, hif.ex_mem_to_reg);
    chk("m_halt", hif.halt, nRST & m_halted);
  end

  always @(posedge CLK) begin
    if (!nRST) begin
      m_halted = 0; m_bubble = 0; m_memwait = 0; m_flush_left = 0;
    end else begin
      m_halted = n_halted; m_bubble = n_bubble; m_memwait = n_memwait;
      m_flush_left = n_flush_left;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic idle();
    hif.ihit = 1; hif.dhit = 0; hif.dmem_req = 0;
    hif.dec_rs = 0; hif.dec_rt = 0; hif.ex_wsel = 0; hif.ex_wen = 0;
    hif.ex_mem_to_reg = 0; hif.mem_wsel = 0; hif.mem_wen = 0;
    hif.mem_branch_taken = 0; hif.mem_halt = 0;
  endtask

  initial begin
    idle();
    nRST = 0;
    sample();
    chk("rst_en", en_vec, 4'h0);
    chk("rst_fl", fl_vec, 4'h0);
    chk("rst_halt", hif.halt, 0);
    step(); nRST = 1;
    sample(); chk("release_en", en_vec, 4'hF);

    // load-use on rs
    step(); hif.ex_wsel = 5; hif.ex_wen = 1; hif.ex_mem_to_reg = 1; hif.dec_rs = 5;
    sample();
    chk("lu_conflict", hif.hu_decode_execute_conflict, 1);
    chk("lu_en", en_vec, 4'b0011);
    chk("lu_fl", fl_vec, 4'b0100);
    step(); idle();
    sample(); chk("lu_after_en", en_vec, 4'hF); chk("lu_after_fl", fl_vec, 4'h0);

    // register $0 guard, then a memory-stage conflict that must not stall
    step(); hif.ex_wsel = 0; hif.ex_wen = 1; hif.ex_mem_to_reg = 1; hif.dec_rt = 0;
    sample(); chk("r0_conflict", hif.hu_decode_execute_conflict, 0); chk("r0_en", en_vec, 4'hF);
    step(); idle(); hif.mem_wsel = 7; hif.mem_wen = 1; hif.dec_rt = 7;
    sample(); chk("dm_conflict", hif.hu_decode_memory_conflict, 1); chk("dm_en", en_vec, 4'hF);

    // load-use while fetch stalls: nothing until ihit
    step(); idle(); hif.ihit = 0; hif.ex_wsel = 3; hif.ex_wen = 1; hif.ex_mem_to_reg = 1; hif.dec_rt = 3;
    sample(); chk("lu_noihit_en", en_vec, 4'h0);
    step(); hif.ihit = 1;
    sample(); chk("lu_ihit_en", en_vec, 4'b0011);
    step(); idle();
    sample(); chk("lu2_after_en", en_vec, 4'hF);

    // memory wait for three cycles
    step(); idle(); hif.dmem_req = 1;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("mw_wait_en", en_vec, 4'h0);
      step();
    end
    hif.dhit = 1;
    sample(); chk("mw_dhit_en", en_vec, 4'hF);
    step(); idle();
    sample(); chk("mw_run_en", en_vec, 4'hF);

    // dhit arrives without ihit
    step(); hif.dmem_req = 1;
    sample(); chk("mwn_wait_en", en_vec, 4'h0);
    step(); hif.ihit = 0; hif.dhit = 1;
    sample(); chk("mwn_dhit_en", en_vec, 4'h0);
    step(); idle();
    sample(); chk("mwn_run_en", en_vec, 4'hF);

    // reset asserted in the middle of a memory wait
    step(); hif.dmem_req = 1;
    sample();
    step(); nRST = 0;
    sample(); chk("rstmw_en", en_vec, 4'h0); chk("rstmw_fl", fl_vec, 4'h0);
    step(); nRST = 1; idle();
    sample(); chk("rstmw_rel_en", en_vec, 4'hF);

    // taken branch, two flush cycles in total
    step(); hif.mem_branch_taken = 1;
    sample(); chk("br_fl", fl_vec, 4'b1110); chk("br_en", en_vec, 4'b0001);
    step(); idle();
    sample(); chk("br2_fl", fl_vec, 4'b1000); chk("br2_en", en_vec, 4'b0111);
    step();
    sample(); chk("br3_fl", fl_vec, 4'h0); chk("br3_en", en_vec, 4'hF);

    // taken branch with a fetch gap before the extra flush
    step(); hif.mem_branch_taken = 1;
    sample();
    step(); idle(); hif.ihit = 0;
    sample(); chk("brg_gap_fl", fl_vec, 4'h0); chk("brg_gap_en", en_vec, 4'h0);
    step(); hif.ihit = 1;
    sample(); chk("brg_fl", fl_vec, 4'b1000);
    step();
    sample(); chk("brg_done_fl", fl_vec, 4'h0);

    // halt wins over a same-cycle branch
    step(); hif.mem_halt = 1; hif.mem_branch_taken = 1;
    sample(); chk("hb_fl", fl_vec, 4'h0); chk("hb_en", en_vec, 4'b0001);
    step(); idle();
    sample(); chk("halt_set", hif.halt, 1); chk("halt_en", en_vec, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step(); hif.ihit = ~hif.ihit; hif.mem_branch_taken = 1;
      sample(); chk("halted_en", en_vec, 4'h0); chk("halted_fl", fl_vec, 4'h0);
      chk("halted_halt", hif.halt, 1);
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
